// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit and the decoder that feeds it.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Unsigned restoring divider retiring BITS_PER_CYCLE quotient bits per step.
module mdu_divider #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned LW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_n, quo_n;
    logic [LW-1:0]    left_q, left_n;
    logic [WIDTH:0]   trial;

    // Outputs show the state after the current step, so a commit on the
    // final step edge sees the finished result.
    always_comb begin
        rem_n = rem_q;
        quo_n = quo_q;
        trial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (LW'(i) < left_q) begin
                trial = {rem_n, quo_n[WIDTH-1]} - {1'b0, dvs_q};
                rem_n = trial[WIDTH] ? {rem_n[WIDTH-2:0], quo_n[WIDTH-1]} : trial[WIDTH-1:0];
                quo_n = {quo_n[WIDTH-2:0], ~trial[WIDTH]};
            end
        end
        left_n = (left_q > LW'(BITS_PER_CYCLE)) ? left_q - LW'(BITS_PER_CYCLE) : '0;
    end

    assign quotient  = quo_n;
    assign remainder = rem_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            left_q <= '0;
        end else if (load) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
            left_q <= LW'(WIDTH);
        end else if (step) begin
            rem_q  <= rem_n;
            quo_q  <= quo_n;
            left_q <= left_n;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit holding HI/LO; multi-cycle mult/div with cancel and done pulse.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned BPC  = (WIDTH + DIV_CYCLES - 1) / DIV_CYCLES;
    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] pend_q;
    logic               use_pend_q, neg_q_q, neg_r_q;
    logic               accept, commit, is_mul, is_div, is_sdiv;
    logic               rs_neg, rt_neg, div_zero, div_ovf;
    logic [WIDTH-1:0]   rs_mag, rt_mag, div_quo, div_rem, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_s, prod_u;

    assign is_mul  = (op == MDU_MULT) || (op == MDU_MULTU);
    assign is_div  = (op == MDU_DIV) || (op == MDU_DIVU);
    assign is_sdiv = (op == MDU_DIV);
    assign rs_neg  = is_sdiv && rs_data[WIDTH-1];
    assign rt_neg  = is_sdiv && rt_data[WIDTH-1];
    assign rs_mag  = rs_neg ? -rs_data : rs_data;
    assign rt_mag  = rt_neg ? -rt_data : rt_data;

    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{WIDTH{rs_data[WIDTH-1]}}, rs_data} * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
    assign prod_u = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

    assign div_zero = (rt_data == '0);
    assign div_ovf  = is_sdiv && (rs_data == {1'b1, {(WIDTH-1){1'b0}}}) && (rt_data == '1);

    assign quo_fix = neg_q_q ? -div_quo : div_quo;
    assign rem_fix = neg_r_q ? -div_rem : div_rem;

    mdu_divider #(
        .WIDTH         (WIDTH),
        .BITS_PER_CYCLE(BPC)
    ) u_divider (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept && is_div),
        .step     (state_q == ST_DIV),
        .dividend (rs_mag),
        .divisor  (rt_mag),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                accept = start && !busy && !cancel && (op <= MDU_MTLO);
                if (accept && is_mul)      state_d = ST_MUL;
                else if (accept && is_div) state_d = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                // The final cycle commits even if cancel arrives with it.
                if (cnt_q == CW'(1)) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cancel) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi         <= '0;
            lo         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= '0;
            use_pend_q <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
        end else begin
            busy <= (state_d != ST_IDLE);
            done <= commit;
            if (accept) begin
                case (op)
                    MDU_MTHI: hi <= rs_data;
                    MDU_MTLO: lo <= rs_data;
                    MDU_MULT, MDU_MULTU: begin
                        pend_q     <= (op == MDU_MULT) ? prod_s : prod_u;
                        use_pend_q <= 1'b1;
                        cnt_q      <= CW'(MULT_CYCLES);
                    end
                    MDU_DIV, MDU_DIVU: begin
                        pend_q     <= div_zero ? {rs_data, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, rs_data};
                        use_pend_q <= div_zero || div_ovf;
                        neg_q_q    <= rs_neg ^ rt_neg;
                        neg_r_q    <= rs_neg;
                        cnt_q      <= CW'(DIV_CYCLES);
                    end
                    default: ;
                endcase
            end else if (state_q != ST_IDLE) begin
                cnt_q <= (state_d == ST_IDLE) ? '0 : cnt_q - 1'b1;
                if (commit) {hi, lo} <= use_pend_q ? pend_q : {rem_fix, quo_fix};
            end
        end
    end

endmodule
